// File: rtl/exers_mc_pkg.sv
// rtl/exers_mc_pkg.sv - shared widths, op encodings and entry type for the multi-cycle ALU reservation station
package exers_mc_pkg;

  localparam int ROBID_W = 7;
  localparam int RD_W    = 6;
  localparam int OP_W    = 5;
  localparam int XLEN    = 32;

  localparam logic [OP_W-1:0] OP_MUL = 5'b10000;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10001;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic               busy1;
    logic               busy2;
  } rs_entry_t;

  // A pending operand carries its producer ROB id in its low bits.
  function automatic logic tag_hit(input logic busy, input logic [XLEN-1:0] opnd,
                                   input logic wb_valid, input logic [ROBID_W-1:0] wb_robid);
    return wb_valid & busy & (opnd[ROBID_W-1:0] == wb_robid);
  endfunction

endpackage

// File: rtl/exers_mc_if.sv
// rtl/exers_mc_if.sv - dispatch, writeback, issue and flush signals of the reservation station
interface exers_mc_if;
  import exers_mc_pkg::*;

  logic               decode_exers_valid;
  logic [OP_W-1:0]    decode_exers_op;
  logic [ROBID_W-1:0] decode_robid;
  logic [RD_W-1:0]    decode_rd;
  logic               decode_op1_busy;
  logic               decode_op2_busy;
  logic [XLEN-1:0]    decode_op1;
  logic [XLEN-1:0]    decode_op2;
  logic               exers_stall;

  logic               wb_valid;
  logic [ROBID_W-1:0] wb_robid;
  logic [XLEN-1:0]    wb_result;

  logic               exers_mcalu_issue;
  logic [OP_W-1:0]    exers_mcalu_op;
  logic [ROBID_W-1:0] exers_robid;
  logic [RD_W-1:0]    exers_rd;
  logic [XLEN-1:0]    exers_op1;
  logic [XLEN-1:0]    exers_op2;
  logic               mcalu_stall;

  logic               rob_flush;

  modport master (
    output decode_exers_valid, decode_exers_op, decode_robid, decode_rd,
           decode_op1_busy, decode_op2_busy, decode_op1, decode_op2,
           wb_valid, wb_robid, wb_result, mcalu_stall, rob_flush,
    input  exers_stall, exers_mcalu_issue, exers_mcalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

  modport slave (
    input  decode_exers_valid, decode_exers_op, decode_robid, decode_rd,
           decode_op1_busy, decode_op2_busy, decode_op1, decode_op2,
           wb_valid, wb_robid, wb_result, mcalu_stall, rob_flush,
    output exers_stall, exers_mcalu_issue, exers_mcalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

endinterface

// File: rtl/exers_mc_entry.sv
// rtl/exers_mc_entry.sv - one reservation-station slot: registers whatever the queue loads into it, woken by writeback
module exers_mc_entry
  import exers_mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               load_valid_i,
  input  rs_entry_t          load_ent_i,
  input  logic               wb_valid_i,
  input  logic [ROBID_W-1:0] wb_robid_i,
  input  logic [XLEN-1:0]    wb_result_i,
  output logic               valid_o,
  output rs_entry_t          ent_o
);

  logic      valid_q, valid_d;
  rs_entry_t ent_q, ent_d;

  // Wakeup is applied to the incoming contents, so held, shifted and freshly dispatched entries all capture alike.
  always_comb begin
    valid_d = load_valid_i & ~clr_i;
    ent_d   = load_ent_i;
    if (tag_hit(load_ent_i.busy1, load_ent_i.op1, wb_valid_i, wb_robid_i)) begin
      ent_d.op1   = wb_result_i;
      ent_d.busy1 = 1'b0;
    end
    if (tag_hit(load_ent_i.busy2, load_ent_i.op2, wb_valid_i, wb_robid_i)) begin
      ent_d.op2   = wb_result_i;
      ent_d.busy2 = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign valid_o = valid_q;
  assign ent_o   = ent_q;

endmodule

// File: rtl/exers_mc.sv
// rtl/exers_mc.sv - age-ordered collapsing reservation station feeding the multi-cycle ALU
module exers_mc
  import exers_mc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  exers_mc_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic [IW-1:0] sel;
  logic          any_ready, issue_fire, disp_fire;
  logic [DEPTH-1:0] ready;
  rs_entry_t     disp_ent;

  logic      slot_valid [DEPTH];
  rs_entry_t slot_ent   [DEPTH];
  logic      nxt_valid  [DEPTH];
  rs_entry_t nxt_ent    [DEPTH];
  logic      load_valid [DEPTH];
  rs_entry_t load_ent   [DEPTH];

  assign disp_ent = '{op: bus.decode_exers_op, robid: bus.decode_robid, rd: bus.decode_rd,
                      op1: bus.decode_op1, op2: bus.decode_op2,
                      busy1: bus.decode_op1_busy, busy2: bus.decode_op2_busy};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g < DEPTH - 1) begin : g_nxt
      assign nxt_valid[g] = slot_valid[g+1];
      assign nxt_ent[g]   = slot_ent[g+1];
    end else begin : g_last
      assign nxt_valid[g] = 1'b0;
      assign nxt_ent[g]   = slot_ent[g];
    end

    exers_mc_entry u_entry (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (bus.rob_flush),
      .load_valid_i (load_valid[g]),
      .load_ent_i   (load_ent[g]),
      .wb_valid_i   (bus.wb_valid),
      .wb_robid_i   (bus.wb_robid),
      .wb_result_i  (bus.wb_result),
      .valid_o      (slot_valid[g]),
      .ent_o        (slot_ent[g])
    );
  end

  always_comb begin
    ready     = '0;
    sel       = '0;
    any_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = slot_valid[i] & ~slot_ent[i].busy1 & ~slot_ent[i].busy2;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel       = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign bus.exers_stall = (count_q == CW'(DEPTH));
  assign issue_fire      = any_ready & ~bus.mcalu_stall & ~bus.rob_flush;
  assign disp_fire       = bus.decode_exers_valid & ~bus.exers_stall & ~bus.rob_flush;
  assign wr_idx          = count_q - CW'(issue_fire);

  // Slots at or above the issued one take their younger neighbour; dispatch lands on the first free slot after that.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      load_valid[i] = slot_valid[i];
      load_ent[i]   = slot_ent[i];
      if (issue_fire && (i >= int'(sel))) begin
        load_valid[i] = nxt_valid[i];
        load_ent[i]   = nxt_ent[i];
      end
      if (disp_fire && (CW'(i) == wr_idx)) begin
        load_valid[i] = 1'b1;
        load_ent[i]   = disp_ent;
      end
    end
  end

  always_comb begin
    count_d = wr_idx + CW'(disp_fire);
    if (bus.rob_flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.exers_mcalu_issue = any_ready;
  assign bus.exers_mcalu_op    = slot_ent[sel].op;
  assign bus.exers_robid       = slot_ent[sel].robid;
  assign bus.exers_rd          = slot_ent[sel].rd;
  assign bus.exers_op1         = slot_ent[sel].op1;
  assign bus.exers_op2         = slot_ent[sel].op2;

endmodule

// File: doc/exers_mc.md
EXERS_MC -- requirements
Module: exers_mc

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries (2..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 decode_exers_valid  input  1  dispatch request for one multi-cycle-ALU op.
REQ-005 decode_exers_op  input  5  op code, passed unchanged to exers_mcalu_op.
REQ-006 decode_robid  input  7  ROB id of the dispatched op.
REQ-007 decode_rd  input  6  destination register tag.
REQ-008 decode_op1_busy / decode_op2_busy  input  1 each  operand pending; if 1, low 7 bits of operand are the producer ROB id.
REQ-009 decode_op1 / decode_op2  input  32 each  operand value, or producer tag when busy.
REQ-010 exers_stall  output  1  dispatch refused this cycle.
REQ-011 wb_valid / wb_robid / wb_result  input  1/7/32  writeback broadcast: valid, producer tag, value.
REQ-012 exers_mcalu_issue  output  1  an issuable entry is presented.
REQ-013 exers_mcalu_op / exers_robid / exers_rd / exers_op1 / exers_op2  output  5/7/6/32/32  fields of the presented entry.
REQ-014 mcalu_stall  input  1  consumer cannot accept; presented entry is held.
REQ-015 rob_flush  input  1  discard all entries.

Function
REQ-016 Entries SHALL form an age-ordered collapsing queue: slot 0 oldest, valid slots contiguous from slot 0.
REQ-017 Each entry SHALL hold op, robid, rd, two 32-bit operands and two busy bits; ready = valid & ~busy1 & ~busy2.
REQ-018 exers_stall SHALL equal (count == DEPTH), independent of same-cycle issue.
REQ-019 Dispatch with decode_exers_valid & ~exers_stall & ~rob_flush SHALL write the entry into slot count (after same-cycle collapse), count +1.
REQ-020 Dispatch-time bypass: a busy operand whose tag equals wb_robid while wb_valid SHALL be stored as ready with wb_result.
REQ-021 Wakeup: each valid entry with busy operand and tag == wb_robid under wb_valid SHALL capture wb_result and clear busy at the clock edge; it becomes issuable the following cycle.
REQ-022 Select: exers_mcalu_issue SHALL be 1 iff any ready entry exists; outputs SHALL carry the lowest-index (oldest) ready entry, combinationally from entry state.
REQ-023 Issue SHALL complete when exers_mcalu_issue & ~mcalu_stall; that entry is removed, younger entries shift down one slot, order preserved.
REQ-024 While mcalu_stall=1 the presented entry SHALL stay; if an older entry becomes ready meanwhile, selection SHALL switch to it.
REQ-025 Simultaneous issue and dispatch SHALL both occur in one cycle; count unchanged.
REQ-026 Simultaneous wakeup and shift SHALL apply the captured value to the entry in its new slot.
REQ-027 rob_flush SHALL clear all valid bits at the next edge and suppress dispatch and issue-completion that cycle; exers_mcalu_issue is not gated by rob_flush.
REQ-028 Latency: dispatch of ready operands to exers_mcalu_issue = 1 cycle; wakeup to issue = 1 cycle.
REQ-029 Outputs when exers_mcalu_issue=0 are don't-care.

Reset
REQ-030 On rst all valid bits and count SHALL clear asynchronously; exers_stall=0 and exers_mcalu_issue=0 while rst is high and after release.
REQ-031 Payload registers SHALL NOT require reset.
REQ-032 rst mid-operation SHALL drop all entries with no issue.

Structure
REQ-033 ROB-id width (7), rd width (6), op width (5) and the MUL/DIV op encodings SHALL be constants in the shared core package.
REQ-034 One sub-module exers_mc_entry (storage + wakeup compare for one slot) SHALL be instantiated DEPTH times; select and collapse logic stay in exers_mc.

Verification
REQ-035 Dispatch op=5'b10000, op1=7, op2=6, both ready, mcalu_stall=0 -> next cycle issue=1, exers_op1=7, exers_op2=6; following cycle issue=0.
REQ-036 Dispatch A (op1 busy, tag 12), then B ready -> B issues first; wb_valid, robid 12, result 0x55 -> next cycle A issues with exers_op1=0x55.
REQ-037 Fill 4 ready entries with mcalu_stall=1 -> exers_stall=1, fifth dispatch dropped; release stall -> entries issue in dispatch order, one per cycle.
REQ-038 Dispatch with op2 busy tag 3 in same cycle as wb_valid robid 3 result 0x99 -> entry issues next cycle with exers_op2=0x99.
REQ-039 3 entries valid, assert rob_flush with concurrent dispatch -> next cycle issue=0, exers_stall=0, count=0.
REQ-040 Assert rst asynchronously mid-cycle with 2 entries -> issue falls immediately without clock; no issue after release.
